// File: rtl/transaction_engine.sv
// Account bank with validated, atomic two-party transfers.
// Requests arrive over valid/ready and take four cycles each.
module transaction_engine #(
    parameter int BAL_W = 8,
    parameter int TAG_W = 3,
    parameter logic [TAG_W-1:0] VALID_TAG = TAG_W'(6),
    parameter int NUM_ACCTS = 4,
    parameter int ID_W = 2,
    parameter int INIT_BAL = 100,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_src,
    input  logic [ID_W-1:0]  req_dst,
    input  logic [BAL_W-1:0] req_amount,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             init_en,
    input  logic [ID_W-1:0]  init_id,
    input  logic [BAL_W-1:0] init_value,
    input  logic [ID_W-1:0]  rd_id,
    output logic [BAL_W-1:0] rd_balance,
    output logic             done,
    output logic [2:0]       status,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, DONE} state_t;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_BAD_TAG  = 3'd1;
    localparam logic [2:0] ST_BAD_ID   = 3'd2;
    localparam logic [2:0] ST_NO_FUNDS = 3'd3;
    localparam logic [2:0] ST_OVERFLOW = 3'd4;
    localparam logic [ID_W:0] NUM_ID = (ID_W+1)'(NUM_ACCTS);

    state_t state;
    state_t next_state;

    logic [BAL_W-1:0] bal [NUM_ACCTS];
    logic [ID_W-1:0]  src_q;
    logic [ID_W-1:0]  dst_q;
    logic [BAL_W-1:0] amt_q;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       result;
    logic [2:0]       check_res;
    logic [BAL_W-1:0] src_bal;
    logic [BAL_W-1:0] dst_bal;
    logic [BAL_W:0]   dst_sum;
    logic             accept;
    logic             commit_ok;

    // Out-of-range IDs read as zero rather than indexing past the bank.
    function automatic logic [BAL_W-1:0] bal_of(input logic [ID_W-1:0] id);
        bal_of = '0;
        for (int i = 0; i < NUM_ACCTS; i++) begin
            if (id == ID_W'(i)) bal_of = bal[i];
        end
    endfunction

    assign req_ready  = (state == IDLE) && !init_en;
    assign accept     = req_valid && req_ready;
    assign done       = (state == DONE);
    assign rd_balance = bal_of(rd_id);
    assign commit_ok  = (state == COMMIT) && (result == ST_OK);

    always_comb begin
        src_bal   = bal_of(src_q);
        dst_bal   = bal_of(dst_q);
        dst_sum   = {1'b0, dst_bal} + {1'b0, amt_q};
        check_res = ST_OK;
        if (tag_q != VALID_TAG) begin
            check_res = ST_BAD_TAG;
        end else if (({1'b0, src_q} >= NUM_ID) || ({1'b0, dst_q} >= NUM_ID)
                     || (src_q == dst_q)) begin
            check_res = ST_BAD_ID;
        end else if (amt_q > src_bal) begin
            check_res = ST_NO_FUNDS;
        end else if (dst_sum[BAL_W]) begin
            check_res = ST_OVERFLOW;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = CHECK;
            CHECK:   next_state = COMMIT;
            COMMIT:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_ACCTS; i++) bal[i] <= BAL_W'(INIT_BAL);
            src_q     <= '0;
            dst_q     <= '0;
            amt_q     <= '0;
            tag_q     <= '0;
            result    <= ST_OK;
            status    <= ST_OK;
            txn_count <= '0;
        end else begin
            if (accept) begin
                src_q <= req_src;
                dst_q <= req_dst;
                amt_q <= req_amount;
                tag_q <= req_tag;
            end
            if (state == CHECK) result <= check_res;
            if (state == COMMIT) status <= result;
            if (commit_ok && (txn_count != '1)) txn_count <= txn_count + 1'b1;
            // An OK result guarantees src != dst, so each slot sees one update.
            for (int i = 0; i < NUM_ACCTS; i++) begin
                if ((state == IDLE) && init_en && (init_id == ID_W'(i))) begin
                    bal[i] <= init_value;
                end else if (commit_ok && (src_q == ID_W'(i))) begin
                    bal[i] <= bal[i] - amt_q;
                end else if (commit_ok && (dst_q == ID_W'(i))) begin
                    bal[i] <= bal[i] + amt_q;
                end
            end
        end
    end

endmodule
